vga_timing_decoder: RTL and testbench
=====================================

Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the VGA timing generator.
- Consumes the hSync, vSync and active strobes of a VGA stream and recovers pixel coordinates.
- Measures line and frame totals and declares lock when they match the expected mode.
- Used for video capture and as an in-system checker on the generator output.

Parameters:
- WIDTH, 640, visible pixels per line.
- HEIGHT, 480, visible lines per frame.
- H_LINE, 800, expected clocks per line (hSync falling edge to hSync falling edge).
- V_LINE, 525, expected lines per frame (vSync falling edge to vSync falling edge).

Ports:
- clk25  in  1  25 MHz pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- hSync  in  1  horizontal sync; low during the sync pulse.
- vSync  in  1  vertical sync; low during the sync pulse.
- activeIn  in  1  visible-area strobe.
- locked  out  1  timing matches the parameters.
- pixelValid  out  1  activeIn & locked, pipelined.
- x  out  10  recovered column; 0 outside the active area.
- y  out  9  recovered row; 0 outside the active area.
- frameStart  out  1  one-cycle pulse on pixel (0,0) while locked.
- syncError  out  1  one-cycle pulse on loss of lock.
- hTotal  out  10  last measured line length in clocks.
- vTotal  out  10  last measured frame length in lines.

Behaviour:
- Reset (reset_n low, async): every register and every output is 0; FSM goes to SEARCH.
- Stage 1 registers the inputs (hs_q, vs_q, act_q). Stage 1b holds their previous values (hs_p, vs_p, act_p).
  - hsFall = hs_p & ~hs_q
  - vsFall = vs_p & ~vs_q
  - actRise = ~act_p & act_q
  - actFall = act_p & ~act_q
- Stage 2 registers all outputs. Total latency from input pin to output is 2 clocks.
- hCnt (10 bit) counts clocks per line:
  - on hsFall: hTotal <= hCnt+1 and hCnt <= 0;
  - otherwise hCnt increments, saturating at 1023.
  - Reaching 1023 raises a timeout condition.
- vCnt (10 bit) counts hsFall events per frame:
  - on vsFall: vTotal <= vCnt + (hsFall ? 1 : 0) and vCnt <= 0.
  - A coincident hsFall is counted into the closing frame.
- x and y recovery:
  - x: on actRise x <= 0; while act_q & act_p x <= x+1, saturating at 1023; when act_q is low x <= 0.
  - yLine (9 bit) clears on vsFall and increments on actFall, saturating at 511.
  - y <= act_q ? yLine : 0.
- FSM:
  - SEARCH -> MEASURE on the first vsFall.
  - MEASURE tracks lineOk, which is cleared if any hsFall in the frame gives hTotal != H_LINE.
    - At the next vsFall: if lineOk and vTotal == V_LINE, go to LOCKED.
    - Otherwise stay in MEASURE and re-arm lineOk.
  - LOCKED drops to SEARCH, with a one-cycle syncError pulse, on any of:
    - hsFall with hTotal != H_LINE;
    - vsFall with vTotal != V_LINE;
    - hCnt timeout;
    - actFall with x+1 != WIDTH.
  - locked = (state == LOCKED), registered.
- frameStart: 1 for one cycle when locked, actRise and yLine == 0.
- Error vs. edge priority: if an error and a vsFall coincide, the error wins. The FSM goes to SEARCH, then needs two more vsFalls to relock.
- Outputs under loss of lock: pixelValid goes low the same cycle locked drops. x and y keep tracking, and hTotal/vTotal keep updating.

Decomposition:
- Shared package vga_pkg holds the timing constants (WIDTH, HEIGHT, porch and sync widths, H_LINE, V_LINE) and the FSM state enum (SEARCH, MEASURE, LOCKED). The generator is refactored onto the same package.
- One sub-module, vga_edge_detect: a 2-flop register plus rise/fall pulse generator, instantiated 3 times.

Test Plan:
- Generator driven back to back after reset:
  - locked rises at the 2nd vsFall;
  - hTotal = 800, vTotal = 525.
- Locked, generator hPos=p, vPos=v in the visible area:
  - 2 clocks later x = p, y = v, pixelValid = 1;
  - frameStart pulses exactly once per frame at (0,0).
- One line stretched to 801 clocks while locked:
  - syncError pulses once and locked falls;
  - hTotal = 801;
  - relock after 2 clean frames.
- hSync held high for more than 1023 clocks:
  - hCnt saturates at 1023;
  - timeout causes syncError and state SEARCH.
- reset_n asserted mid-frame:
  - all outputs 0 immediately, asynchronously;
  - after release, locked = 0 until 2 vsFalls are seen.
- Active run of 639 pixels with correct syncs:
  - syncError at actFall, locked drops.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the lock-state encoding used by
// both the timing generator and the timing decoder.
package vga_pkg;

    localparam int WIDTH   = 640;
    localparam int H_FRONT = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_LINE  = WIDTH + H_FRONT + H_SYNC + H_BACK;

    localparam int HEIGHT  = 480;
    localparam int V_FRONT = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_LINE  = HEIGHT + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vga_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// Registers one strobe twice (current and previous sample) and derives
// single-cycle rise/fall pulses from the two registered copies.
module vga_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic cur_q;
    logic cur_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        cur_d  = din;
        prev_d = cur_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    assign level = cur_q;
    assign rise  = cur_q & ~prev_q;
    assign fall  = prev_q & ~cur_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates from hSync, vSync
// and the active strobe, measures line/frame totals and tracks lock to the mode.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int WIDTH  = vga_pkg::WIDTH,
    parameter int HEIGHT = vga_pkg::HEIGHT,
    parameter int H_LINE = vga_pkg::H_LINE,
    parameter int V_LINE = vga_pkg::V_LINE
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       activeIn,
    output logic       locked,
    output logic       pixelValid,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frameStart,
    output logic       syncError,
    output logic [9:0] hTotal,
    output logic [9:0] vTotal,
    output logic [1:0] state_dbg
);

    if (WIDTH < 1 || WIDTH > 1023 || HEIGHT < 1 || HEIGHT > 511 ||
        H_LINE < 1 || H_LINE > 1023 || V_LINE < 1 || V_LINE > 1023) begin : g_bad_params
        $error("vga_timing_decoder: timing parameter outside counter range");
    end

    localparam logic [9:0]  H_LINE_C = 10'(H_LINE);
    localparam logic [9:0]  V_LINE_C = 10'(V_LINE);
    localparam logic [10:0] WIDTH_C  = 11'(WIDTH);

    logic       hs_fall;
    logic       vs_fall;
    logic       act_q;
    logic       act_rise;
    logic       act_fall;
    logic [1:0] unused_hs;
    logic [1:0] unused_vs;

    vga_edge_detect u_hs (
        .clk   (clk25),
        .rst_n (reset_n),
        .din   (hSync),
        .level (unused_hs[0]),
        .rise  (unused_hs[1]),
        .fall  (hs_fall)
    );

    vga_edge_detect u_vs (
        .clk   (clk25),
        .rst_n (reset_n),
        .din   (vSync),
        .level (unused_vs[0]),
        .rise  (unused_vs[1]),
        .fall  (vs_fall)
    );

    vga_edge_detect u_act (
        .clk   (clk25),
        .rst_n (reset_n),
        .din   (activeIn),
        .level (act_q),
        .rise  (act_rise),
        .fall  (act_fall)
    );

    vga_state_e state_q, state_d;
    logic       line_ok_q, line_ok_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [9:0] h_total_q, h_total_d;
    logic [9:0] v_total_q, v_total_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [8:0] y_line_q, y_line_d;
    logic       locked_q, locked_d;
    logic       pixel_valid_q, pixel_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       sync_error_q, sync_error_d;

    logic [9:0] h_total_new;
    logic [9:0] v_total_new;
    logic       timeout;
    logic       line_bad;
    logic       frame_bad;
    logic       width_bad;

    always_comb begin
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        h_total_d    = h_total_q;
        v_total_d    = v_total_q;
        x_d          = x_q;
        y_line_d     = y_line_q;
        state_d      = state_q;
        line_ok_d    = line_ok_q;
        sync_error_d = 1'b0;

        // A coincident hsFall belongs to the frame that the vsFall closes.
        h_total_new = h_cnt_q + 10'd1;
        v_total_new = v_cnt_q + {9'd0, hs_fall};
        timeout     = (h_cnt_q == 10'd1023);

        if (hs_fall) begin
            h_total_d = h_total_new;
            h_cnt_d   = 10'd0;
        end else if (!timeout) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end

        if (vs_fall) begin
            v_total_d = v_total_new;
            v_cnt_d   = 10'd0;
        end else if (hs_fall && v_cnt_q != 10'd1023) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end

        if (!act_q || act_rise) begin
            x_d = 10'd0;
        end else if (x_q != 10'd1023) begin
            x_d = x_q + 10'd1;
        end

        if (vs_fall) begin
            y_line_d = 9'd0;
        end else if (act_fall && y_line_q != 9'd511) begin
            y_line_d = y_line_q + 9'd1;
        end
        y_d = act_q ? y_line_q : 9'd0;

        line_bad  = hs_fall && (h_total_new != H_LINE_C);
        frame_bad = vs_fall && (v_total_new != V_LINE_C);
        width_bad = act_fall && (({1'b0, x_q} + 11'd1) != WIDTH_C);

        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d   = MEASURE;
                    line_ok_d = 1'b1;
                end
            end
            MEASURE: begin
                if (line_bad) begin
                    line_ok_d = 1'b0;
                end
                if (vs_fall) begin
                    if (line_ok_q && !line_bad && (v_total_new == V_LINE_C)) begin
                        state_d = LOCKED;
                    end
                    line_ok_d = 1'b1;
                end
            end
            LOCKED: begin
                // Any error outranks a coincident vsFall; relock restarts from SEARCH.
                if (line_bad || frame_bad || timeout || width_bad) begin
                    state_d      = SEARCH;
                    sync_error_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d      = (state_d == LOCKED);
        pixel_valid_d = act_q & locked_d;
        frame_start_d = locked_d & act_rise & (y_line_q == 9'd0);
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEARCH;
            line_ok_q     <= 1'b0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            h_total_q     <= 10'd0;
            v_total_q     <= 10'd0;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
            y_line_q      <= 9'd0;
            locked_q      <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_ok_q     <= line_ok_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            x_q           <= x_d;
            y_q           <= y_d;
            y_line_q      <= y_line_d;
            locked_q      <= locked_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign locked     = locked_q;
    assign pixelValid = pixel_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign frameStart = frame_start_q;
    assign syncError  = sync_error_q;
    assign hTotal     = h_total_q;
    assign vTotal     = v_total_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a reduced 16x8 mode
// (24 clocks per line, 12 lines per frame) driven by an in-bench generator.
module tb_vga_timing_decoder;
    import vga_pkg::*;

    localparam int TW       = 16;
    localparam int TH       = 8;
    localparam int THL      = 24;
    localparam int TVL      = 12;
    localparam int TF       = THL * TVL;
    localparam int H_SYNC_S = 18;
    localparam int H_SYNC_E = 22;
    localparam int V_SYNC_S = 9;
    localparam int V_SYNC_E = 11;

    logic       clk25;
    logic       reset_n;
    logic       hSync;
    logic       vSync;
    logic       activeIn;
    logic       locked;
    logic       pixelValid;
    logic [9:0] x;
    logic [8:0] y;
    logic       frameStart;
    logic       syncError;
    logic [9:0] hTotal;
    logic [9:0] vTotal;
    logic [1:0] state_dbg;

    int   checks;
    int   failures;
    int   se_cnt;
    int   fs_cnt;
    int   nxt_h, nxt_v;
    int   cur_h, cur_v, prev_h, prev_v;
    logic cur_act, prev_act;

    vga_timing_decoder #(
        .WIDTH  (TW),
        .HEIGHT (TH),
        .H_LINE (THL),
        .V_LINE (TVL)
    ) dut (
        .clk25      (clk25),
        .reset_n    (reset_n),
        .hSync      (hSync),
        .vSync      (vSync),
        .activeIn   (activeIn),
        .locked     (locked),
        .pixelValid (pixelValid),
        .x          (x),
        .y          (y),
        .frameStart (frameStart),
        .syncError  (syncError),
        .hTotal     (hTotal),
        .vTotal     (vTotal),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick(input logic hs, input logic vs, input logic act);
        hSync    = hs;
        vSync    = vs;
        activeIn = act;
        @(posedge clk25);
        #1;
        if (syncError) se_cnt++;
        if (frameStart) fs_cnt++;
    endtask

    task automatic gen_step(input bit hold, input bit kill_act);
        logic hs, vs, act;
        hs = !(nxt_h >= H_SYNC_S && nxt_h < H_SYNC_E);
        vs = !(nxt_v >= V_SYNC_S && nxt_v < V_SYNC_E);
        act = (nxt_h < TW) && (nxt_v < TH) && !kill_act;
        prev_act = cur_act;
        prev_h   = cur_h;
        prev_v   = cur_v;
        cur_act  = act;
        cur_h    = nxt_h;
        cur_v    = nxt_v;
        tick(hs, vs, act);
        if (!hold) begin
            if (nxt_h == THL - 1) begin
                nxt_h = 0;
                nxt_v = (nxt_v == TVL - 1) ? 0 : nxt_v + 1;
            end else begin
                nxt_h++;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 2 * TF && !(nxt_h == h && nxt_v == v); i++) gen_step(0, 0);
    endtask

    // scenarios
    task automatic test_reset();
        reset_n = 1'b0; hSync = 1'b1; vSync = 1'b1; activeIn = 1'b0;
        repeat (3) @(posedge clk25);
        #1;
        checks++;
        if ({locked, pixelValid, frameStart, syncError} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {locked, pixelValid, frameStart, syncError});
        end
        checks++;
        if (x !== 10'd0 || y !== 9'd0) begin
            failures++; $display("FAIL reset_xy got x=%0d y=%0d exp 0 0", x, y);
        end
        checks++;
        if (hTotal !== 10'd0 || vTotal !== 10'd0) begin
            failures++; $display("FAIL reset_totals got h=%0d v=%0d exp 0 0", hTotal, vTotal);
        end
        checks++;
        if (state_dbg !== SEARCH) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, SEARCH);
        end
        @(negedge clk25);
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back_lock();
        // vsFalls are driven on steps 216 and 504; lock shows one step later.
        for (int i = 0; i < 505; i++) gen_step(0, 0);
        checks++;
        if (locked !== 1'b0 || state_dbg !== MEASURE) begin
            failures++; $display("FAIL prelock got locked=%0b state=%0d exp 0 %0d", locked, state_dbg, MEASURE);
        end
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b1 || state_dbg !== LOCKED) begin
            failures++; $display("FAIL lock_rise got locked=%0b state=%0d exp 1 %0d", locked, state_dbg, LOCKED);
        end
        checks++;
        if (hTotal !== 10'(THL)) begin
            failures++; $display("FAIL lock_htotal got=%0d exp=%0d", hTotal, THL);
        end
        checks++;
        if (vTotal !== 10'(TVL)) begin
            failures++; $display("FAIL lock_vtotal got=%0d exp=%0d", vTotal, TVL);
        end
    endtask

    task automatic test_coords();
        int bad;
        logic exp_fs;
        run_to(0, 0);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (x !== 10'd0 || y !== 9'd0 || pixelValid !== 1'b1 || frameStart !== 1'b1) begin
            failures++; $display("FAIL origin got x=%0d y=%0d pv=%0b fs=%0b exp 0 0 1 1", x, y, pixelValid, frameStart);
        end
        run_to(5, 3);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (x !== 10'd5 || y !== 9'd3 || pixelValid !== 1'b1) begin
            failures++; $display("FAIL pixel_5_3 got x=%0d y=%0d pv=%0b exp 5 3 1", x, y, pixelValid);
        end
        run_to(TW - 1, TH - 1);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (x !== 10'(TW - 1) || y !== 9'(TH - 1) || frameStart !== 1'b0) begin
            failures++; $display("FAIL last_pixel got x=%0d y=%0d fs=%0b exp %0d %0d 0", x, y, frameStart, TW - 1, TH - 1);
        end
        bad = 0; fs_cnt = 0; se_cnt = 0;
        for (int i = 0; i < TF; i++) begin
            gen_step(0, 0);
            exp_fs = prev_act && prev_h == 0 && prev_v == 0;
            if (x !== (prev_act ? 10'(prev_h) : 10'd0) || y !== (prev_act ? 9'(prev_v) : 9'd0) ||
                pixelValid !== prev_act || frameStart !== exp_fs) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL coord_sweep got mismatches=%0d exp=0", bad);
        end
        checks++;
        if (fs_cnt != 1) begin
            failures++; $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
        end
        checks++;
        if (se_cnt != 0) begin
            failures++; $display("FAIL locked_sync_error got=%0d exp=0", se_cnt);
        end
    endtask

    task automatic test_stretch();
        run_to(22, 3);
        gen_step(1, 0);
        run_to(18, 4);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (syncError !== 1'b1 || locked !== 1'b0) begin
            failures++; $display("FAIL stretch_error got se=%0b locked=%0b exp 1 0", syncError, locked);
        end
        checks++;
        if (hTotal !== 10'(THL + 1)) begin
            failures++; $display("FAIL stretch_htotal got=%0d exp=%0d", hTotal, THL + 1);
        end
        gen_step(0, 0);
        checks++;
        if (syncError !== 1'b0) begin
            failures++; $display("FAIL stretch_pulse_width got=%0b exp=0", syncError);
        end
        run_to(0, 9);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (state_dbg !== MEASURE || locked !== 1'b0) begin
            failures++; $display("FAIL stretch_measure got state=%0d locked=%0b exp %0d 0", state_dbg, locked, MEASURE);
        end
        run_to(0, 9);
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL stretch_early_lock got=%0b exp=0", locked);
        end
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL stretch_relock got=%0b exp=1", locked);
        end
    endtask

    task automatic test_timeout();
        run_to(0, 11);
        se_cnt = 0;
        for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (se_cnt != 1) begin
            failures++; $display("FAIL timeout_error_count got=%0d exp=1", se_cnt);
        end
        checks++;
        if (state_dbg !== SEARCH || locked !== 1'b0) begin
            failures++; $display("FAIL timeout_state got state=%0d locked=%0b exp %0d 0", state_dbg, locked, SEARCH);
        end
        // A saturated count of 1023 plus one truncates to 0 in the 10-bit total.
        run_to(18, 11);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (hTotal !== 10'd0) begin
            failures++; $display("FAIL timeout_htotal got=%0d exp=0", hTotal);
        end
    endtask

    task automatic test_mid_reset();
        run_to(0, 9);
        gen_step(0, 0);
        run_to(0, 9);
        gen_step(0, 0);
        gen_step(0, 0);
        run_to(5, 4);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b1 || x !== 10'd5 || y !== 9'd4) begin
            failures++; $display("FAIL pre_reset got locked=%0b x=%0d y=%0d exp 1 5 4", locked, x, y);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({locked, pixelValid, frameStart, syncError} !== 4'b0000) begin
            failures++; $display("FAIL async_reset_flags got=%b exp=0000", {locked, pixelValid, frameStart, syncError});
        end
        checks++;
        if (x !== 10'd0 || y !== 9'd0 || hTotal !== 10'd0 || vTotal !== 10'd0) begin
            failures++; $display("FAIL async_reset_values got x=%0d y=%0d h=%0d v=%0d exp 0 0 0 0", x, y, hTotal, vTotal);
        end
        @(negedge clk25);
        reset_n = 1'b1;
        run_to(0, 9);
        gen_step(0, 0);
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b0 || state_dbg !== MEASURE) begin
            failures++; $display("FAIL reset_first_vs got locked=%0b state=%0d exp 0 %0d", locked, state_dbg, MEASURE);
        end
        run_to(0, 9);
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL reset_early_lock got=%0b exp=0", locked);
        end
        gen_step(0, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL reset_relock got=%0b exp=1", locked);
        end
    endtask

    task automatic test_short_active();
        run_to(TW - 1, 2);
        gen_step(0, 1);
        gen_step(0, 0);
        checks++;
        if (syncError !== 1'b1 || locked !== 1'b0) begin
            failures++; $display("FAIL short_active_error got se=%0b locked=%0b exp 1 0", syncError, locked);
        end
        checks++;
        if (state_dbg !== SEARCH || pixelValid !== 1'b0) begin
            failures++; $display("FAIL short_active_state got state=%0d pv=%0b exp %0d 0", state_dbg, pixelValid, SEARCH);
        end
        gen_step(0, 0);
        checks++;
        if (syncError !== 1'b0) begin
            failures++; $display("FAIL short_active_pulse got=%0b exp=0", syncError);
        end
    endtask

    initial begin
        checks = 0; failures = 0; se_cnt = 0; fs_cnt = 0;
        nxt_h = 0; nxt_v = 0;
        cur_h = 0; cur_v = 0; prev_h = 0; prev_v = 0;
        cur_act = 1'b0; prev_act = 1'b0;
        test_reset();
        test_back_to_back_lock();
        test_coords();
        test_stretch();
        test_timeout();
        test_mid_reset();
        test_short_active();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
